// File: rtl/des_keyed_scanchain.sv
// des_keyed_scanchain -- iterative DES encrypt/decrypt engine.
//
// The key is loaded at runtime into KC/KD. The subkey for each round is
// derived on the fly from the working C/D registers, so no key ROM is needed.
// ROUNDS_PER_CYCLE Feistel rounds are chained combinationally in each clock.
// Every flop sits on one scan chain.
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   key_load, key     : load PC1(key) into KC/KD (honoured only in IDLE)
//   in_valid/in_ready : input handshake, block offered on starttext
//   starttext         : plaintext or ciphertext
//   encrypt_ndecrypt  : 1 = encrypt, 0 = decrypt, sampled on accept
//   out_valid/out_ready : output handshake, result held on finishtext
//   finishtext        : result register
//   busy              : FSM is in ROUND
//   scan_enable, scan_in, scan_out : 247-bit serial scan chain
//
// Chain order, from scan_in to scan_out:
//   state(2) rc(4) m(1) KC(28) KD(28) C(28) D(28) L(32) R(32) finishtext(64)
// Within each segment, data enters at bit 0.
module des_keyed_scanchain #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] starttext,
  input  logic        encrypt_ndecrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] finishtext,
  output logic        busy,
  input  logic        scan_enable,
  input  logic        scan_in,
  output logic        scan_out
);

  localparam int N         = 16 / ROUNDS_PER_CYCLE;
  localparam int CHAIN_LEN = 247;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("des_keyed_scanchain: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Permutation tables use standard DES numbering: bit 1 is the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int IPI_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // S-boxes S1..S8, each 4 rows x 16 columns.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] o;
    for (int n = 0; n < 64; n++) o[63-n] = x[64-IP_T[n]];
    return o;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] o;
    for (int n = 0; n < 64; n++) o[63-n] = x[64-IPI_T[n]];
    return o;
  endfunction

  // Parity bits (8, 16, ..., 64) are simply never selected.
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int n = 0; n < 56; n++) o[55-n] = x[64-PC1_T[n]];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int n = 0; n < 48; n++) o[47-n] = x[56-PC2_T[n]];
    return o;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  b;
    for (int n = 0; n < 48; n++) e[47-n] = r[32-E_T[n]];
    e = e ^ k;
    for (int g = 0; g < 8; g++) begin
      b = e[47-6*g -: 6];
      // Row is the outer bit pair, column the inner four bits.
      s[31-4*g -: 4] = 4'(SBOX[64*g + 16*int'({b[5], b[0]}) + int'(b[4:1])]);
    end
    for (int n = 0; n < 32; n++) o[31-n] = s[32-P_T[n]];
    return o;
  endfunction

  function automatic logic [1:0] shift_amt(input logic [4:0] i);
    return (i == 5'd1 || i == 5'd2 || i == 5'd9 || i == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] s);
    return (s == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] s);
    return (s == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  state_t      r_state, w_state_next;
  logic [3:0]  r_rc, w_rc_next;
  logic        r_m, w_m_next;
  logic [27:0] r_kc, r_kd, w_kc_next, w_kd_next;
  logic [27:0] r_c, r_d, w_c_next, w_d_next;
  logic [31:0] r_l, r_r, w_l_next, w_r_next;
  logic [63:0] r_ft, w_ft_next;
  logic [55:0] w_pc1_key;
  logic [CHAIN_LEN-1:0] w_chain, w_shift;

  assign w_pc1_key = pc1(key);

  // Round pipeline: stage gi takes the C/D/L/R produced by stage gi-1.
  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    logic [27:0] w_c_in, w_d_in, w_c_out, w_d_out;
    logic [31:0] w_l_in, w_r_in, w_l_out, w_r_out;
    logic [4:0]  w_idx;
    logic [47:0] w_k;

    if (gi == 0) begin : g_first
      assign w_c_in = r_c;
      assign w_d_in = r_d;
      assign w_l_in = r_l;
      assign w_r_in = r_r;
    end else begin : g_next
      assign w_c_in = g_round[gi-1].w_c_out;
      assign w_d_in = g_round[gi-1].w_d_out;
      assign w_l_in = g_round[gi-1].w_l_out;
      assign w_r_in = g_round[gi-1].w_r_out;
    end

    // Round number i, 1..16.
    assign w_idx = 5'({1'b0, r_rc} * 5'(ROUNDS_PER_CYCLE)) + 5'(gi + 1);

    // Encrypt rotates left before taking the subkey. Decrypt takes the
    // subkey first, then undoes the rotation of round 17-i.
    assign w_c_out = r_m ? rotl(w_c_in, shift_amt(w_idx)) : rotr(w_c_in, shift_amt(5'd17 - w_idx));
    assign w_d_out = r_m ? rotl(w_d_in, shift_amt(w_idx)) : rotr(w_d_in, shift_amt(5'd17 - w_idx));
    assign w_k     = r_m ? pc2({w_c_out, w_d_out}) : pc2({w_c_in, w_d_in});

    assign w_l_out = w_r_in;
    assign w_r_out = w_l_in ^ des_f(w_r_in, w_k);
  end

  always_comb begin
    w_state_next = r_state;
    w_rc_next    = r_rc;
    w_m_next     = r_m;
    w_kc_next    = r_kc;
    w_kd_next    = r_kd;
    w_c_next     = r_c;
    w_d_next     = r_d;
    w_l_next     = r_l;
    w_r_next     = r_r;
    w_ft_next    = r_ft;
    case (r_state)
      S_IDLE: begin
        if (key_load) {w_kc_next, w_kd_next} = w_pc1_key;
        if (in_valid) begin
          {w_l_next, w_r_next} = ip(starttext);
          // A simultaneous key load bypasses straight into the working key.
          {w_c_next, w_d_next} = key_load ? w_pc1_key : {r_kc, r_kd};
          w_m_next     = encrypt_ndecrypt;
          w_rc_next    = 4'd0;
          w_state_next = S_ROUND;
        end
      end
      S_ROUND: begin
        w_c_next  = g_round[ROUNDS_PER_CYCLE-1].w_c_out;
        w_d_next  = g_round[ROUNDS_PER_CYCLE-1].w_d_out;
        w_l_next  = g_round[ROUNDS_PER_CYCLE-1].w_l_out;
        w_r_next  = g_round[ROUNDS_PER_CYCLE-1].w_r_out;
        w_rc_next = r_rc + 4'd1;
        if (r_rc == 4'(N - 1)) begin
          // Final swap: output is IP^-1(R16 || L16).
          w_ft_next    = ip_inv({g_round[ROUNDS_PER_CYCLE-1].w_r_out,
                                 g_round[ROUNDS_PER_CYCLE-1].w_l_out});
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_chain = {r_ft, r_r, r_l, r_d, r_c, r_kd, r_kc, r_m, r_rc, r_state};
  assign w_shift = {w_chain[CHAIN_LEN-2:0], scan_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rc    <= '0;
      r_m     <= 1'b0;
      r_kc    <= '0;
      r_kd    <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_l     <= '0;
      r_r     <= '0;
      r_ft    <= '0;
    end else if (scan_enable) begin
      r_state <= state_t'(w_shift[1:0]);
      r_rc    <= w_shift[5:2];
      r_m     <= w_shift[6];
      r_kc    <= w_shift[34:7];
      r_kd    <= w_shift[62:35];
      r_c     <= w_shift[90:63];
      r_d     <= w_shift[118:91];
      r_l     <= w_shift[150:119];
      r_r     <= w_shift[182:151];
      r_ft    <= w_shift[246:183];
    end else begin
      r_state <= w_state_next;
      r_rc    <= w_rc_next;
      r_m     <= w_m_next;
      r_kc    <= w_kc_next;
      r_kd    <= w_kd_next;
      r_c     <= w_c_next;
      r_d     <= w_d_next;
      r_l     <= w_l_next;
      r_r     <= w_r_next;
      r_ft    <= w_ft_next;
    end
  end

  assign in_ready   = (r_state == S_IDLE) & ~scan_enable;
  assign out_valid  = (r_state == S_DONE) & ~scan_enable;
  assign busy       = (r_state == S_ROUND);
  assign finishtext = r_ft;
  assign scan_out   = w_chain[CHAIN_LEN-1];

endmodule

// File: tb/tb_des_keyed_scanchain.sv
// Testbench for des_keyed_scanchain. The main instance runs with one round
// per cycle. Two more instances (2 and 4 rounds per cycle) share the
// functional inputs, so the table vectors also check their results and
// latencies.
module tb_des_keyed_scanchain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [63:0] key = '0;
  logic        in_valid = 1'b0;
  logic [63:0] starttext = '0;
  logic        encrypt_ndecrypt = 1'b0;
  logic        out_ready = 1'b0;
  logic        scan_enable = 1'b0;
  logic        scan_in = 1'b0;

  logic        in_ready, out_valid, busy, scan_out;
  logic [63:0] finishtext;
  logic        in_ready2, out_valid2, busy2, scan_out2;
  logic [63:0] finishtext2;
  logic        in_ready4, out_valid4, busy4, scan_out4;
  logic [63:0] finishtext4;

  always #5 clk = ~clk;

  des_keyed_scanchain #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .starttext(starttext),
    .encrypt_ndecrypt(encrypt_ndecrypt), .out_valid(out_valid),
    .out_ready(out_ready), .finishtext(finishtext), .busy(busy),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out));

  des_keyed_scanchain #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key),
    .in_valid(in_valid), .in_ready(in_ready2), .starttext(starttext),
    .encrypt_ndecrypt(encrypt_ndecrypt), .out_valid(out_valid2),
    .out_ready(out_ready), .finishtext(finishtext2), .busy(busy2),
    .scan_enable(1'b0), .scan_in(1'b0), .scan_out(scan_out2));

  des_keyed_scanchain #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key),
    .in_valid(in_valid), .in_ready(in_ready4), .starttext(starttext),
    .encrypt_ndecrypt(encrypt_ndecrypt), .out_valid(out_valid4),
    .out_ready(out_ready), .finishtext(finishtext4), .busy(busy4),
    .scan_enable(1'b0), .scan_in(1'b0), .scan_out(scan_out4));

  int n_vec  = 0;
  int n_miss = 0;

  int          lat1, lat2, lat4;
  logic [63:0] res1, res2, res4;

  // mode: 0 = use stored key, 1 = load key in a separate IDLE cycle,
  //       2 = load key together with the accept (bypass)
  typedef struct {
    logic [63:0] k;
    int          mode;
    logic [63:0] txt;
    bit          enc;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] K3  = 64'h0101010101010101;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] PT2 = 64'h8787878787878787;
  localparam logic [63:0] PT3 = 64'h8000000000000000;
  localparam logic [63:0] CT3 = 64'h95F8A5E5DD31D900;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_block(input logic [63:0] k, input int mode,
                             input logic [63:0] txt, input bit enc);
    if (mode == 1) begin
      key      = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
    end
    key              = k;
    key_load         = (mode == 2);
    starttext        = txt;
    encrypt_ndecrypt = enc;
    in_valid         = 1'b1;
    tick();
    in_valid = 1'b0;
    key_load = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
  endtask

  // Waits (bounded) for out_valid on the main instance; records the first
  // cycle each instance raised out_valid, counted from the call.
  task automatic wait_done();
    lat1 = -1; lat2 = -1; lat4 = -1;
    res1 = 'x; res2 = 'x; res4 = 'x;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid2 && lat2 < 0) begin lat2 = c; res2 = finishtext2; end
      if (out_valid4 && lat4 < 0) begin lat4 = c; res4 = finishtext4; end
      if (out_valid) begin lat1 = c; res1 = finishtext; break; end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{k: K1, mode: 1, txt: PT1, enc: 1'b1, exp: CT1};
    vecs[1] = '{k: K1, mode: 0, txt: CT1, enc: 1'b0, exp: PT1};
    vecs[2] = '{k: K2, mode: 2, txt: PT2, enc: 1'b1, exp: 64'h0};
    vecs[3] = '{k: K2, mode: 0, txt: 64'h0, enc: 1'b0, exp: PT2};
    vecs[4] = '{k: K3, mode: 2, txt: PT3, enc: 1'b1, exp: CT3};
    vecs[5] = '{k: K3, mode: 0, txt: CT3, enc: 1'b0, exp: PT3};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finishtext", finishtext, 64'd0);
    check("rst_scan_out", 64'(scan_out), 64'd0);

    // Table-driven known answers on all three instances.
    for (int v = 0; v < 6; v++) begin
      start_block(vecs[v].k, vecs[v].mode, vecs[v].txt, vecs[v].enc);
      wait_done();
      $display("vec %0d: key=%h text=%h enc=%0d -> %h lat=%0d/%0d/%0d",
               v, vecs[v].k, vecs[v].txt, vecs[v].enc, res1, lat1, lat2, lat4);
      check("vec_result_r1", res1, vecs[v].exp);
      check("vec_result_r2", res2, vecs[v].exp);
      check("vec_result_r4", res4, vecs[v].exp);
      check("vec_latency_r1", 64'(lat1), 64'd16);
      check("vec_latency_r2", 64'(lat2), 64'd8);
      check("vec_latency_r4", 64'(lat4), 64'd4);
      release_out();
      check("vec_idle_after", 64'(in_ready), 64'd1);
    end

    // Bypass load, then a zero key_load during ROUND that must be ignored.
    start_block(K2, 2, PT2, 1'b1);
    tick();
    tick();
    key      = 64'h0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    wait_done();
    $display("bypass: %h lat=%0d", res1, lat1);
    check("bypass_result", res1, 64'h0);
    check("bypass_latency", 64'(lat1), 64'd13);
    release_out();
    start_block(64'h0, 0, PT2, 1'b1);
    wait_done();
    $display("ignored key_load: %h lat=%0d", res1, lat1);
    check("ignored_keyload_result", res1, 64'h0);
    check("ignored_keyload_latency", 64'(lat1), 64'd16);
    release_out();

    // Output backpressure with a competing in_valid.
    start_block(K1, 1, PT1, 1'b1);
    wait_done();
    check("bp_result", res1, CT1);
    starttext        = PT1;
    encrypt_ndecrypt = 1'b1;
    in_valid         = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_finishtext", finishtext, CT1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp_next_accept", 64'(busy), 64'd1);
    wait_done();
    $display("backpressure follow-up: %h lat=%0d", res1, lat1);
    check("bp_next_result", res1, CT1);
    check("bp_next_latency", 64'(lat1), 64'd16);
    release_out();

    // Scan loopback mid-ROUND at rc = 3.
    start_block(64'h0, 0, PT1, 1'b1);
    tick();
    tick();
    tick();
    scan_enable = 1'b1;
    #1;
    check("scan_in_ready", 64'(in_ready), 64'd0);
    check("scan_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 247; c++) begin
      scan_in = scan_out;
      tick();
    end
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    #1;
    check("scan_resume_busy", 64'(busy), 64'd1);
    wait_done();
    $display("scan loopback: %h lat=%0d", res1, lat1);
    check("scan_loop_result", res1, CT1);
    check("scan_loop_latency", 64'(lat1), 64'd13);
    release_out();

    // One-hot through the full chain length.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    scan_enable = 1'b1;
    #1;
    check("scan_idle_in_ready", 64'(in_ready), 64'd0);
    scan_in = 1'b1;
    tick();
    scan_in = 1'b0;
    for (int c = 0; c < 245; c++) tick();
    check("onehot_246", 64'(scan_out), 64'd0);
    tick();
    check("onehot_247", 64'(scan_out), 64'd1);
    $display("one-hot: scan_out=%0d after 247 clocks", scan_out);
    scan_enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset mid-ROUND clears state and key.
    start_block(K1, 1, PT1, 1'b1);
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_finishtext", finishtext, 64'd0);
    // Cleared key equals PC1 of the all-parity key 0101..01.
    start_block(64'h0, 0, CT3, 1'b0);
    wait_done();
    $display("after reset, zero key decrypt: %h", res1);
    check("midrst_zero_key", res1, PT3);
    release_out();
    start_block(K1, 1, PT1, 1'b1);
    wait_done();
    $display("after reset, fresh key: %h lat=%0d", res1, lat1);
    check("midrst_fresh_result", res1, CT1);
    check("midrst_fresh_latency", 64'(lat1), 64'd16);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
